// File: rtl/sha256_miner_pkg.sv
// Shared types and constants for the SHA-256 nonce scanner and its neighbours.
package sha256_miner_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } scan_state_e;

  localparam logic [31:0] PAD_WORD4 = 32'h8000_0000;
  localparam logic [31:0] PAD_LEN   = 32'h0000_0280;

  // Word idx of a 512-bit block, word 0 in the least significant bits.
  function automatic logic [31:0] block_word(input logic [511:0] blk, input logic [3:0] idx);
    return blk[{idx, 5'd0} +: 32];
  endfunction

endpackage

// File: rtl/sha256_nonce_scanner_if.sv
// Golden-nonce result port: valid/ready handshake plus the dropped-result counter.
interface sha256_nonce_scanner_if;
  logic        gold_valid;
  logic        gold_ready;
  logic [31:0] gold_nonce;
  logic [15:0] gold_dropped;

  modport master (output gold_valid, output gold_nonce, output gold_dropped, input gold_ready);
  modport slave  (input gold_valid, input gold_nonce, input gold_dropped, output gold_ready);
endinterface

// File: rtl/sha256_nonce_scanner_slot_delay_line.sv
// 1-bit shift register marking which hash_result cycles belong to an issued nonce.
module slot_delay_line #(
  parameter int unsigned DEPTH = 65
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic din,
  output logic dout
);
  logic [DEPTH-1:0] sr;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) sr <= '0;
    else                 sr <= {sr[DEPTH-2:0], din};
  end

  assign dout = sr[DEPTH-1];
endmodule

// File: rtl/sha256_nonce_scanner.sv
// Feeds one nonce per LOOP cycles into sha256_transform and reports nonces whose
// hash has ZERO_BITS leading zeros through a valid/ready result port.
module sha256_nonce_scanner
  import sha256_miner_pkg::*;
#(
  parameter int unsigned LOOP         = 4,
  parameter int unsigned RESULT_DELAY = 65,
  parameter int unsigned ZERO_BITS    = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          work_load,
  input  logic [255:0]                  work_midstate,
  input  logic [95:0]                   work_tail,
  input  logic [31:0]                   nonce_start,
  input  logic [31:0]                   nonce_end,
  output logic                          hash_feedback,
  output logic [5:0]                    hash_cnt,
  output logic [255:0]                  hash_state,
  output logic [511:0]                  hash_input,
  input  logic [255:0]                  hash_result,
  sha256_nonce_scanner_if.master        gold,
  output logic                          busy,
  output logic                          done
);
  localparam int unsigned   DW         = $clog2(RESULT_DELAY);
  localparam logic [5:0]    CNT_LAST   = 6'(LOOP - 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(RESULT_DELAY - 1);

  scan_state_e     state, state_next;
  logic [255:0]    midstate_q;
  logic [95:0]     tail_q;
  logic [31:0]     end_q, nonce, check_nonce;
  logic [5:0]      cnt;
  logic [DW-1:0]   drain_cnt;
  logic            pad_en, slot, tap, golden, run_next;
  logic            unused_hash_bits;

  assign slot     = (state == SCAN) && (cnt == '0);
  assign run_next = (state_next == SCAN) || (state_next == DRAIN);
  // A result landing in the same cycle as new work belongs to the abandoned range.
  assign golden   = tap && (hash_result[255 -: ZERO_BITS] == '0) && !work_load;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      SCAN:    if (slot && (nonce == end_q)) state_next = DRAIN;
      DRAIN:   if (drain_cnt == DRAIN_LAST)  state_next = DONE;
      default: state_next = state;
    endcase
    if (work_load) state_next = SCAN;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      midstate_q  <= '0;
      tail_q      <= '0;
      end_q       <= '0;
      nonce       <= '0;
      check_nonce <= '0;
      cnt         <= '0;
      drain_cnt   <= '0;
      pad_en      <= 1'b0;
    end else if (work_load) begin
      midstate_q  <= work_midstate;
      tail_q      <= work_tail;
      end_q       <= nonce_end;
      nonce       <= nonce_start;
      check_nonce <= nonce_start;
      cnt         <= '0;
      drain_cnt   <= '0;
      pad_en      <= 1'b1;
    end else begin
      if (slot) nonce       <= nonce + 32'd1;
      if (tap)  check_nonce <= check_nonce + 32'd1;
      cnt       <= (!run_next || cnt == CNT_LAST) ? '0 : cnt + 6'd1;
      drain_cnt <= (state == DRAIN) ? drain_cnt + 1'b1 : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gold.gold_valid   <= 1'b0;
      gold.gold_nonce   <= '0;
      gold.gold_dropped <= '0;
    end else begin
      if (gold.gold_valid && gold.gold_ready) gold.gold_valid <= 1'b0;
      if (golden) begin
        if (!gold.gold_valid || gold.gold_ready) begin
          gold.gold_valid <= 1'b1;
          gold.gold_nonce <= check_nonce;
        end else if (gold.gold_dropped != '1) begin
          gold.gold_dropped <= gold.gold_dropped + 16'd1;
        end
      end
    end
  end

  slot_delay_line #(.DEPTH(RESULT_DELAY)) u_slots (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (work_load),
    .din   (slot),
    .dout  (tap)
  );

  assign hash_cnt      = cnt;
  assign hash_feedback = (cnt != '0);
  assign hash_state    = midstate_q;
  // Pad words stay 0 until work is loaded so every output is 0 out of reset.
  assign hash_input    = {pad_en ? PAD_LEN : 32'h0, 320'h0, pad_en ? PAD_WORD4 : 32'h0,
                          nonce, tail_q};
  assign busy          = (state == SCAN) || (state == DRAIN);
  assign done          = (state == DONE);
  assign unused_hash_bits = ^hash_result;
endmodule

// File: tb/tb_sha256_nonce_scanner.sv
// Directed bench: two scanners (LOOP=4 and LOOP=1) each fed by a fixed-latency stub hasher.
module tb_sha256_nonce_scanner;
  import sha256_miner_pkg::*;

  localparam int unsigned RD = 65;

  logic         clk, rst_n, load4, load1;
  logic [255:0] midstate;
  logic [95:0]  tail;
  logic [31:0]  n_start, n_end;
  logic         fb4, fb1, busy4, busy1, done4, done1;
  logic [5:0]   cnt4, cnt1;
  logic [255:0] st4, st1, res4, res1;
  logic [511:0] in4, in1;
  logic [31:0]  pipe4 [RD];
  logic [31:0]  pipe1 [RD];
  int           checks = 0;
  int           errors = 0;

  sha256_nonce_scanner_if g4 ();
  sha256_nonce_scanner_if g1 ();

  sha256_nonce_scanner #(.LOOP(4), .RESULT_DELAY(RD), .ZERO_BITS(32)) dut4 (
    .clk(clk), .rst_n(rst_n), .work_load(load4), .work_midstate(midstate), .work_tail(tail),
    .nonce_start(n_start), .nonce_end(n_end), .hash_feedback(fb4), .hash_cnt(cnt4),
    .hash_state(st4), .hash_input(in4), .hash_result(res4), .gold(g4), .busy(busy4), .done(done4));

  sha256_nonce_scanner #(.LOOP(1), .RESULT_DELAY(RD), .ZERO_BITS(32)) dut1 (
    .clk(clk), .rst_n(rst_n), .work_load(load1), .work_midstate(midstate), .work_tail(tail),
    .nonce_start(n_start), .nonce_end(n_end), .hash_feedback(fb1), .hash_cnt(cnt1),
    .hash_state(st1), .hash_input(in1), .hash_result(res1), .gold(g1), .busy(busy1), .done(done1));

  // Stub hasher: top word is zero only for a few chosen nonces.
  function automatic logic [255:0] stub_hash(input logic [31:0] n);
    if (n == 32'h3 || n == 32'h5 || n == 32'h10 || n == 32'h40) return {32'h0, 224'h5A5A};
    return {32'hDEAD_BEEF, 224'h0};
  endfunction

  assign res4 = stub_hash(pipe4[RD-1]);
  assign res1 = stub_hash(pipe1[RD-1]);

  always @(posedge clk) begin
    pipe4[0] <= block_word(in4, 4'd3);
    pipe1[0] <= block_word(in1, 4'd3);
    for (int i = 1; i < int'(RD); i++) begin
      pipe4[i] <= pipe4[i-1];
      pipe1[i] <= pipe1[i-1];
    end
  end

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_work(input bit sel1, input logic [31:0] s, input logic [31:0] e);
    n_start = s;
    n_end   = e;
    if (sel1) load1 = 1'b1; else load4 = 1'b1;
    tick();
    load1 = 1'b0;
    load4 = 1'b0;
  endtask

  task automatic test_reset();
    g4.gold_ready = 1'b0;
    load_work(1'b0, 32'h10, 32'h1F);
    repeat (69) tick();
    checks++;
    if (g4.gold_valid !== 1'b1 || busy4 !== 1'b1) begin
      errors++; $display("FAIL pre_reset: valid=%b busy=%b required 1 1", g4.gold_valid, busy4);
    end
    rst_n = 1'b0;
    repeat (3) tick();
    checks++;
    if ({fb4, cnt4, busy4, done4} !== '0) begin
      errors++; $display("FAIL reset_ctrl: fb/cnt/busy/done=%b required 0", {fb4, cnt4, busy4, done4});
    end
    checks++;
    if (st4 !== '0 || in4 !== '0) begin
      errors++; $display("FAIL reset_hash: state=%h input=%h required 0", st4, in4);
    end
    checks++;
    if ({g4.gold_valid, g4.gold_nonce, g4.gold_dropped} !== '0) begin
      errors++; $display("FAIL reset_gold: valid=%b nonce=%h dropped=%0d required 0",
                         g4.gold_valid, g4.gold_nonce, g4.gold_dropped);
    end
    checks++;
    if ({fb1, cnt1, busy1, done1, st1, in1, g1.gold_valid} !== '0) begin
      errors++; $display("FAIL reset_dut1: busy=%b done=%b input=%h required 0", busy1, done1, in1);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (busy4 !== 1'b0 || done4 !== 1'b0) begin
      errors++; $display("FAIL post_reset_idle: busy=%b done=%b required 0 0", busy4, done4);
    end
  endtask

  task automatic test_scan();
    int bad_seq = 0;
    int bad_nonce = 0;
    int accepts = 0;
    logic [31:0] acc_nonce = '0;
    g4.gold_ready = 1'b1;
    load_work(1'b0, 32'h10, 32'h1F);
    for (int c = 1; c <= 130; c++) begin
      if (c <= 126) begin
        if (cnt4 !== 6'((c - 1) % 4) || fb4 !== (((c - 1) % 4) != 0) || busy4 !== 1'b1) bad_seq++;
      end
      if ((c - 1) % 4 == 0 && c <= 61) begin
        if (block_word(in4, 4'd3) !== 32'h10 + 32'((c - 1) / 4)) bad_nonce++;
      end
      if (g4.gold_valid && g4.gold_ready) begin accepts++; acc_nonce = g4.gold_nonce; end
      if (c == 1) begin
        checks++;
        if (st4 !== midstate || in4[95:0] !== tail || in4[159:128] !== 32'h8000_0000 ||
            in4[479:160] !== '0 || in4[511:480] !== 32'h0000_0280) begin
          errors++; $display("FAIL block_layout: state=%h input=%h", st4, in4);
        end
      end
      if (c == 66) begin
        checks++;
        if (g4.gold_valid !== 1'b0) begin
          errors++; $display("FAIL gold_early: valid=%b required 0", g4.gold_valid);
        end
      end
      if (c == 67) begin
        checks++;
        if (g4.gold_valid !== 1'b1 || g4.gold_nonce !== 32'h10) begin
          errors++; $display("FAIL gold_rise: valid=%b nonce=%h required 1 00000010", g4.gold_valid, g4.gold_nonce);
        end
      end
      if (c == 126) begin
        checks++;
        if (done4 !== 1'b0 || block_word(in4, 4'd3) !== 32'h20) begin
          errors++; $display("FAIL drain_tail: done=%b nonce=%h required 0 00000020", done4, block_word(in4, 4'd3));
        end
      end
      if (c == 127) begin
        checks++;
        if (done4 !== 1'b1 || busy4 !== 1'b0 || cnt4 !== 6'd0) begin
          errors++; $display("FAIL done_rise: done=%b busy=%b cnt=%0d required 1 0 0", done4, busy4, cnt4);
        end
      end
      tick();
    end
    checks++;
    if (bad_seq !== 0) begin errors++; $display("FAIL cnt_sequence: bad cycles=%0d required 0", bad_seq); end
    checks++;
    if (bad_nonce !== 0) begin errors++; $display("FAIL slot_nonces: bad slots=%0d required 0", bad_nonce); end
    checks++;
    if (accepts !== 1 || acc_nonce !== 32'h10) begin
      errors++; $display("FAIL gold_once: accepts=%0d nonce=%h required 1 00000010", accepts, acc_nonce);
    end
  endtask

  task automatic test_backpressure();
    g4.gold_ready = 1'b0;
    load_work(1'b0, 32'h0, 32'h7);
    for (int c = 1; c <= 100; c++) begin
      if (c == 79) begin
        checks++;
        if (g4.gold_valid !== 1'b1 || g4.gold_nonce !== 32'h3) begin
          errors++; $display("FAIL bp_first: valid=%b nonce=%h required 1 00000003", g4.gold_valid, g4.gold_nonce);
        end
      end
      if (c == 86 || c == 87) begin
        checks++;
        if (g4.gold_dropped !== 16'(c - 86)) begin
          errors++; $display("FAIL bp_drop_c%0d: dropped=%0d required %0d", c, g4.gold_dropped, c - 86);
        end
      end
      tick();
    end
    checks++;
    if (g4.gold_valid !== 1'b1 || g4.gold_nonce !== 32'h3 || g4.gold_dropped !== 16'd1 || done4 !== 1'b1) begin
      errors++; $display("FAIL bp_hold: valid=%b nonce=%h dropped=%0d done=%b required 1 00000003 1 1",
                         g4.gold_valid, g4.gold_nonce, g4.gold_dropped, done4);
    end
    g4.gold_ready = 1'b1;
    tick();
    checks++;
    if (g4.gold_valid !== 1'b0) begin errors++; $display("FAIL bp_release: valid=%b required 0", g4.gold_valid); end
  endtask

  task automatic test_preempt();
    int valid_cycles = 0;
    g4.gold_ready = 1'b0;
    load_work(1'b0, 32'h40, 32'h4F);
    repeat (10) tick();
    load_work(1'b0, 32'h100, 32'h103);
    checks++;
    if (block_word(in4, 4'd3) !== 32'h100 || cnt4 !== 6'd0 || busy4 !== 1'b1) begin
      errors++; $display("FAIL preempt_issue: nonce=%h cnt=%0d busy=%b required 00000100 0 1",
                         block_word(in4, 4'd3), cnt4, busy4);
    end
    for (int c = 1; c <= 80; c++) begin
      if (g4.gold_valid) valid_cycles++;
      if (c == 78 || c == 79) begin
        checks++;
        if (done4 !== (c == 79)) begin
          errors++; $display("FAIL preempt_done_c%0d: done=%b required %0d", c, done4, c == 79);
        end
      end
      tick();
    end
    checks++;
    if (valid_cycles !== 0 || g4.gold_dropped !== 16'd1) begin
      errors++; $display("FAIL preempt_stale: valid cycles=%0d dropped=%0d required 0 1", valid_cycles, g4.gold_dropped);
    end
  endtask

  task automatic test_wrap();
    int bad = 0;
    g1.gold_ready = 1'b1;
    load_work(1'b1, 32'hFFFF_FFFE, 32'h0000_0001);
    for (int c = 1; c <= 72; c++) begin
      if (fb1 !== 1'b0 || cnt1 !== 6'd0) bad++;
      if (c <= 4 && (block_word(in1, 4'd3) !== 32'hFFFF_FFFE + 32'(c - 1) || busy1 !== 1'b1)) bad++;
      if (c == 5) begin
        checks++;
        if (busy1 !== 1'b1 || block_word(in1, 4'd3) !== 32'h2) begin
          errors++; $display("FAIL wrap_drain: busy=%b nonce=%h required 1 00000002", busy1, block_word(in1, 4'd3));
        end
      end
      if (c == 69 || c == 70) begin
        checks++;
        if (done1 !== (c == 70) || busy1 !== (c == 69)) begin
          errors++; $display("FAIL wrap_done_c%0d: done=%b busy=%b", c, done1, busy1);
        end
      end
      tick();
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL wrap_slots: bad cycles=%0d required 0", bad); end
  endtask

  task automatic test_single();
    int bad = 0;
    load_work(1'b1, 32'h7, 32'h7);
    checks++;
    if (block_word(in1, 4'd3) !== 32'h7 || busy1 !== 1'b1) begin
      errors++; $display("FAIL single_issue: nonce=%h busy=%b required 00000007 1", block_word(in1, 4'd3), busy1);
    end
    for (int c = 1; c <= 70; c++) begin
      if (fb1 !== 1'b0) bad++;
      if (c >= 2 && c <= 66 && (block_word(in1, 4'd3) !== 32'h8 || busy1 !== 1'b1)) bad++;
      if (c == 66 || c == 67) begin
        checks++;
        if (done1 !== (c == 67)) begin
          errors++; $display("FAIL single_done_c%0d: done=%b required %0d", c, done1, c == 67);
        end
      end
      tick();
    end
    checks++;
    if (bad !== 0 || g1.gold_valid !== 1'b0) begin
      errors++; $display("FAIL single_slot: bad cycles=%0d valid=%b required 0 0", bad, g1.gold_valid);
    end
  endtask

  initial begin
    clk = 1'b0;
    rst_n = 1'b0;
    load4 = 1'b0;
    load1 = 1'b0;
    midstate = 256'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210_0F1E_2D3C_4B5A_6978_8796_A5B4_C3D2_E1F0;
    tail = 96'hCAFE_F00D_1234_5678_9ABC_DEF0;
    n_start = '0;
    n_end = '0;
    g4.gold_ready = 1'b0;
    g1.gold_ready = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    test_reset();
    test_scan();
    test_backpressure();
    test_preempt();
    test_wrap();
    test_single();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sha256_nonce_scanner.md
# sha256_nonce_scanner

Work feeder and result checker for the SHA-256 transform pipeline. It drives the transform's `feedback`/`cnt`/`rx_state`/`rx_input` inputs with one nonce per issue slot over a loaded range. It watches the transform's registered `tx_hash` output and reports every nonce whose hash meets the zero-bits target through a valid/ready result port. It sits between the work/communication logic and one `sha256_transform` instance.

## Interface
- `LOOP`, 4: transform loop factor; power of two, 1..64; one issue slot every `LOOP` cycles.
- `RESULT_DELAY`, 65: cycles from an issue slot to the `hash_result` cycle that carries that nonce's hash; ≥ 2.
- `ZERO_BITS`, 32: number of MSBs of `hash_result` that must be zero for a golden nonce; 1..64.
- `clk` in 1: single clock.
- `rst_n` in 1: synchronous, active-low reset.
- `work_load` in 1: one-cycle pulse; latch new work and (re)start the scan.
- `work_midstate` in 256: state passed to the transform.
- `work_tail` in 96: block-2 words 0..2.
- `nonce_start` in 32: first nonce issued.
- `nonce_end` in 32: last nonce issued (inclusive).
- `hash_feedback` out 1: to transform `feedback`.
- `hash_cnt` out 6: to transform `cnt`.
- `hash_state` out 256: to transform `rx_state`.
- `hash_input` out 512: to transform `rx_input`.
- `hash_result` in 256: from transform `tx_hash`.
- `gold_valid` out 1: golden nonce pending.
- `gold_ready` in 1: consumer accepts.
- `gold_nonce` out 32: nonce value.
- `gold_dropped` out 16: saturating count of goldens lost to backpressure.
- `busy` out 1: state is SCAN or DRAIN.
- `done` out 1: state is DONE.

## Operation
- States: IDLE, SCAN, DRAIN, DONE. `rst_n` low → IDLE. `work_load` from any state → SCAN.
- On `work_load`: latch midstate, tail, start and end; `nonce` ← `nonce_start`; `check_nonce` ← `nonce_start`; `cnt` ← 0; slot delay line cleared.
- `hash_state` = latched midstate.
- `hash_input` word layout:
  - words 0..2: tail
  - word 3: `nonce`
  - word 4: 32'h80000000
  - words 5..14: 0
  - word 15: 32'h00000280
- `cnt` runs 0..`LOOP`-1 and wraps, in SCAN and DRAIN; it is held at 0 in IDLE and DONE.
- `hash_feedback` = (`cnt` != 0); it is always 0 when `LOOP`=1.
- Issue slot: a SCAN cycle with `cnt`=0. After each slot, `nonce` increments mod 2^32.
- If the slot's nonce equals `nonce_end`, go to DRAIN instead.
- DRAIN lasts `RESULT_DELAY` cycles, then DONE. DONE holds until `work_load`.
- Slot delay line: a 1-bit shift register, `RESULT_DELAY` deep, that marks issue slots.
- A marked tap means `hash_result` in that cycle belongs to `check_nonce`. `check_nonce` increments on every marked tap.
- Golden condition: marked tap and `hash_result[255 -: ZERO_BITS]` == 0.
- If a golden occurs while `gold_valid`=0, or while `gold_valid`&`gold_ready` in the same cycle: load `gold_nonce` and set `gold_valid`.
- Otherwise drop the golden and increment `gold_dropped`, saturating at 16'hFFFF.
- `gold_valid` holds until a cycle with `gold_ready`=1.
- A pending golden survives `work_load`. `gold_dropped` clears only on reset.
- Wrap-around: if `nonce_end` < `nonce_start`, the scan passes FFFFFFFF → 0 and continues until `nonce_end`.
- If `nonce_start` == `nonce_end`, exactly one nonce is issued.

## Timing
- Reset: every output is 0, including `hash_*`, `gold_*`, `busy` and `done`. The delay line is cleared.
- All outputs are registered.
- First issue slot is the cycle after `work_load`. Subsequent slots follow every `LOOP` cycles.
- A slot's hash is checked exactly `RESULT_DELAY` cycles after that slot.
- `gold_valid` rises the cycle after the checked `hash_result`.
- `done` rises `RESULT_DELAY`+1 cycles after the last slot.
- `work_load` mid-scan: in-flight slots are unmarked, so their results are never reported.
- `work_load` and a golden in the same cycle: the golden is discarded, and `gold_dropped` is not incremented.
- `rst_n` low mid-scan: everything returns to IDLE/zero on the next edge.

## Structure
- `sha256_miner_pkg` holds:
  - the state enum
  - the pad words `PAD_WORD4` = 32'h80000000 and `PAD_LEN` = 32'h00000280
  - a 32-bit word-index helper function
- One sub-module, `slot_delay_line` (parameter `DEPTH`): a 1-bit shift register with synchronous clear.

## Test plan
- Reset: hold `rst_n` low 3 cycles mid-scan. All outputs are 0 and the state is IDLE. `work_load` afterward scans normally.
- Stub hasher with delay 65 returns hash MSW 0 only for nonce 0x10. `LOOP`=4, range 0x10..0x1F gives:
  - 16 slots, 4 cycles apart
  - `gold_nonce`=0x10 reported exactly once
  - `done` 66 cycles after the slot carrying 0x1F
- Backpressure: goldens at 0x3 and 0x5, `gold_ready`=0. Result: `gold_nonce`=0x3 is held, `gold_dropped`=1. Raising `gold_ready` clears `gold_valid`.
- Wrap: start FFFFFFFE, end 00000001, `LOOP`=1. Issued nonces are FFFFFFFE, FFFFFFFF, 0, 1; then DRAIN, then DONE.
- Preempt: `work_load` (start 0x100) 10 cycles after a golden-producing slot of old work. The old golden is not reported, and 0x100 is issued the next cycle.
- `LOOP`=1, single nonce (start = end = 0x7): exactly one slot with `hash_feedback`=0 throughout, and `done` after 66 cycles.
